// File: rtl/ppg_cal_ctrl.sv
// ppg_cal_ctrl: per-channel DC-comp and PGA gain calibration, then slotted multiplexed sampling.
// Latency: one sample per SLOT_LEN cycles in RUN; no backpressure (adc valid every cycle, sample_valid is a strobe).
// Option PPG_SAMPLE_AVG_EN: sample_data is the truncated mean of the slot's last 4 adc samples.
module ppg_cal_ctrl #(
  parameter int NUM_CH     = 2,
  parameter int ADC_W      = 8,
  parameter int DC_W       = 7,
  parameter int GAIN_W     = 4,
  parameter int WIN_LEN    = 1000,
  parameter int SETTLE     = 4,
  parameter int TGT_LO     = 120,
  parameter int TGT_HI     = 135,
  parameter int CLIP_LO    = 10,
  parameter int CLIP_HI    = 245,
  parameter int DC_STEP_DN = 5,
  parameter int DC_STEP_UP = 1,
  parameter int GAIN_INIT  = 7,
  parameter int MAX_ITER   = 64,
  parameter int SLOT_LEN   = 10,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADC_W-1:0]  adc,
  output logic [NUM_CH-1:0] led_en,
  output logic [DC_W-1:0]   dc_comp,
  output logic [GAIN_W-1:0] pga_gain,
  output logic              clk_filter,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] cal_fail,
  output logic [ADC_W-1:0]  sample_data,
  output logic [CH_W-1:0]   sample_ch,
  output logic              sample_valid
);

  localparam int CNT_MAX = (WIN_LEN > SLOT_LEN) ? WIN_LEN : SLOT_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IT_W    = $clog2(MAX_ITER + 1);
  localparam int MID_W   = ADC_W + 1;

  localparam logic [DC_W-1:0]   DC_MAX     = '1;
  localparam logic [GAIN_W-1:0] GAIN_MAX   = '1;
  localparam logic [GAIN_W-1:0] GAIN_INI   = GAIN_W'(GAIN_INIT);
  localparam logic [DC_W-1:0]   DC_DN      = DC_W'(DC_STEP_DN);
  localparam logic [DC_W-1:0]   DC_UP      = DC_W'(DC_STEP_UP);
  localparam logic [MID_W-1:0]  MID_LO     = MID_W'(TGT_LO);
  localparam logic [MID_W-1:0]  MID_HI     = MID_W'(TGT_HI);
  localparam logic [ADC_W-1:0]  CLP_LO     = ADC_W'(CLIP_LO);
  localparam logic [ADC_W-1:0]  CLP_HI     = ADC_W'(CLIP_HI);
  localparam logic [CNT_W-1:0]  SETTLE_END = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]  WIN_END    = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0]  SLOT_END   = CNT_W'(SLOT_LEN - 1);
  localparam logic [IT_W-1:0]   ITER_LIM   = IT_W'(MAX_ITER);
  localparam logic [CH_W-1:0]   CH_LAST    = CH_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] LED0       = NUM_CH'(1);

  typedef enum logic [2:0] {IDLE, SETTLE_W, MEAS, DC_ADJ, GAIN_ADJ, NEXT_CH, RUN} state_t;

  state_t            state, state_n;
  logic [CH_W-1:0]   ch, ch_n, nxt_ch;
  logic              ph_gain, ph_gain_n;
  logic              g_first, g_first_n;
  logic              g_up, g_up_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IT_W-1:0]   iter, iter_n, it_nx;
  logic [ADC_W-1:0]  vmin, vmin_n, vmax, vmax_n;
  logic [NUM_CH-1:0] led_en_n, cal_fail_n;
  logic [DC_W-1:0]   dc_comp_n;
  logic [GAIN_W-1:0] pga_gain_n, st_gain;
  logic              busy_n, done_n, sample_valid_n;
  logic [ADC_W-1:0]  sample_data_n, smp;
  logic [CH_W-1:0]   sample_ch_n;
  logic              dc_we, gain_we;
  logic [MID_W-1:0]  mid;
  logic              clipped, in_win, up;

  logic [DC_W-1:0]   dc_store   [NUM_CH];
  logic [GAIN_W-1:0] gain_store [NUM_CH];

  assign mid     = ({1'b0, vmin} + {1'b0, vmax}) >> 1;
  assign in_win  = (mid >= MID_LO) && (mid <= MID_HI);
  assign clipped = (vmin <= CLP_LO) || (vmax >= CLP_HI);
  // The first gain window of a channel decides the search direction.
  assign up      = g_first ? !clipped : g_up;
  assign it_nx   = iter + 1'b1;
  assign nxt_ch  = (ch == CH_LAST) ? '0 : ch + 1'b1;

`ifdef PPG_SAMPLE_AVG_EN
  logic [ADC_W-1:0] h1, h2, h3;
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      h1 <= '0;
      h2 <= '0;
      h3 <= '0;
    end else begin
      h1 <= adc;
      h2 <= h1;
      h3 <= h2;
    end
  end
  assign smp = ADC_W'(({2'b00, adc} + {2'b00, h1} + {2'b00, h2} + {2'b00, h3}) >> 2);
`else
  assign smp = adc;
`endif

  always_comb begin
    state_n        = state;
    ch_n           = ch;
    ph_gain_n      = ph_gain;
    g_first_n      = g_first;
    g_up_n         = g_up;
    cnt_n          = cnt;
    iter_n         = iter;
    vmin_n         = vmin;
    vmax_n         = vmax;
    led_en_n       = led_en;
    dc_comp_n      = dc_comp;
    pga_gain_n     = pga_gain;
    busy_n         = busy;
    done_n         = done;
    cal_fail_n     = cal_fail;
    sample_data_n  = sample_data;
    sample_ch_n    = sample_ch;
    sample_valid_n = 1'b0;
    dc_we          = 1'b0;
    gain_we        = 1'b0;
    st_gain        = pga_gain;

    case (state)
      IDLE: ;
      SETTLE_W: begin
        if (cnt == SETTLE_END) begin
          cnt_n   = '0;
          vmin_n  = '1;
          vmax_n  = '0;
          state_n = MEAS;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      MEAS: begin
        vmin_n = (adc < vmin) ? adc : vmin;
        vmax_n = (adc > vmax) ? adc : vmax;
        if (cnt == WIN_END) begin
          cnt_n   = '0;
          state_n = ph_gain ? GAIN_ADJ : DC_ADJ;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DC_ADJ: begin
        iter_n  = it_nx;
        state_n = SETTLE_W;
        if ((mid < MID_LO && dc_comp == '0) || (mid > MID_HI && dc_comp == DC_MAX) ||
            (!in_win && it_nx == ITER_LIM)) begin
          cal_fail_n[ch] = 1'b1;
          dc_we          = 1'b1;
          ph_gain_n      = 1'b1;
          g_first_n      = 1'b1;
        end else if (mid < MID_LO) begin
          dc_comp_n = (dc_comp < DC_DN) ? '0 : dc_comp - DC_DN;
        end else if (mid > MID_HI) begin
          dc_comp_n = ((DC_MAX - dc_comp) < DC_UP) ? DC_MAX : dc_comp + DC_UP;
        end else begin
          dc_we     = 1'b1;
          ph_gain_n = 1'b1;
          g_first_n = 1'b1;
        end
      end
      GAIN_ADJ: begin
        g_first_n = 1'b0;
        g_up_n    = up;
        state_n   = NEXT_CH;
        if (up) begin
          if (clipped) begin
            gain_we = 1'b1;
            st_gain = pga_gain - 1'b1;
          end else if (pga_gain != GAIN_MAX) begin
            pga_gain_n = pga_gain + 1'b1;
            state_n    = SETTLE_W;
          end else begin
            gain_we = 1'b1;
          end
        end else begin
          if (!clipped) begin
            gain_we = 1'b1;
          end else if (pga_gain != '0) begin
            pga_gain_n = pga_gain - 1'b1;
            state_n    = SETTLE_W;
          end else begin
            gain_we        = 1'b1;
            cal_fail_n[ch] = 1'b1;
          end
        end
      end
      NEXT_CH: begin
        cnt_n = '0;
        if (ch != CH_LAST) begin
          ch_n       = ch + 1'b1;
          dc_comp_n  = DC_MAX;
          pga_gain_n = GAIN_INI;
          led_en_n   = LED0 << (ch + 1'b1);
          ph_gain_n  = 1'b0;
          iter_n     = '0;
          state_n    = SETTLE_W;
        end else begin
          // Slot 0 of RUN starts with channel 0 settings already applied.
          ch_n       = '0;
          busy_n     = 1'b0;
          done_n     = 1'b1;
          led_en_n   = LED0;
          dc_comp_n  = dc_store[0];
          pga_gain_n = gain_store[0];
          state_n    = RUN;
        end
      end
      RUN: begin
        if (cnt == SLOT_END) begin
          cnt_n          = '0;
          sample_valid_n = 1'b1;
          sample_data_n  = smp;
          sample_ch_n    = ch;
          ch_n           = nxt_ch;
          led_en_n       = LED0 << nxt_ch;
          dc_comp_n      = dc_store[nxt_ch];
          pga_gain_n     = gain_store[nxt_ch];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (start) begin
      state_n        = SETTLE_W;
      ch_n           = '0;
      ph_gain_n      = 1'b0;
      cnt_n          = '0;
      iter_n         = '0;
      led_en_n       = LED0;
      dc_comp_n      = DC_MAX;
      pga_gain_n     = GAIN_INI;
      cal_fail_n     = '0;
      busy_n         = 1'b1;
      done_n         = 1'b0;
      sample_valid_n = 1'b0;
      dc_we          = 1'b0;
      gain_we        = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ch           <= '0;
      ph_gain      <= 1'b0;
      g_first      <= 1'b0;
      g_up         <= 1'b0;
      cnt          <= '0;
      iter         <= '0;
      vmin         <= '1;
      vmax         <= '0;
      led_en       <= '0;
      dc_comp      <= DC_MAX;
      pga_gain     <= '0;
      clk_filter   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cal_fail     <= '0;
      sample_data  <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        dc_store[i]   <= '0;
        gain_store[i] <= '0;
      end
    end else begin
      state        <= state_n;
      ch           <= ch_n;
      ph_gain      <= ph_gain_n;
      g_first      <= g_first_n;
      g_up         <= g_up_n;
      cnt          <= cnt_n;
      iter         <= iter_n;
      vmin         <= vmin_n;
      vmax         <= vmax_n;
      led_en       <= led_en_n;
      dc_comp      <= dc_comp_n;
      pga_gain     <= pga_gain_n;
      clk_filter   <= ~clk_filter;
      busy         <= busy_n;
      done         <= done_n;
      cal_fail     <= cal_fail_n;
      sample_data  <= sample_data_n;
      sample_ch    <= sample_ch_n;
      sample_valid <= sample_valid_n;
      if (dc_we)   dc_store[ch]   <= dc_comp;
      if (gain_we) gain_store[ch] <= st_gain;
    end
  end

endmodule

// File: tb/tb_ppg_cal_ctrl.sv
// Bench for ppg_cal_ctrl: an optical plant model drives adc from led_en/dc_comp/pga_gain,
// and a search model predicts per-channel stored settings, failures and RUN sample stream.
module tb_ppg_cal_ctrl;
  localparam int NCH   = 2;
  localparam int WIN   = 16;
  localparam int SLOT  = 10;
  localparam int GINIT = 7;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] adc = 8'd0;
  logic [1:0] led_en;
  logic [6:0] dc_comp;
  logic [3:0] pga_gain;
  logic       clk_filter, busy, done;
  logic [1:0] cal_fail;
  logic [7:0] sample_data;
  logic [0:0] sample_ch;
  logic       sample_valid;

  ppg_cal_ctrl #(.NUM_CH(NCH), .WIN_LEN(WIN), .SLOT_LEN(SLOT)) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .adc(adc),
    .led_en(led_en), .dc_comp(dc_comp), .pga_gain(pga_gain), .clk_filter(clk_filter),
    .busy(busy), .done(done), .cal_fail(cal_fail), .sample_data(sample_data),
    .sample_ch(sample_ch), .sample_valid(sample_valid)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_err = 0, cyc = 0;
  int off [2], amp0 [2], kg [2];
  int m_dc [2], m_gain [2], m_fail [2], m_dchg [2], m_gchg [2];
  int o_dchg [2], o_gchg [2];
  bit run_chk = 0, tog = 0;
  int run_ch, n_valid, last_v;
  int prev_led = 0, prev_dc = 0, prev_gain = 0;
  bit prev_busy = 0;
  int hist [$];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int clampi(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int amp(input int c, input int g);
    return amp0[c] + kg[c] * g;
  endfunction

  // Plant: the signal alternates between centre-A and centre+A, so a window sees both extremes.
  task automatic model(input int c);
    int dc, g, iter, lo, hi, mid;
    bit clip, up, first;
    dc = 127; iter = 0; m_fail[c] = 0; m_dchg[c] = 0; m_gchg[c] = 0;
    forever begin
      iter++;
      lo = clampi(off[c] - dc - amp(c, GINIT));
      hi = clampi(off[c] - dc + amp(c, GINIT));
      mid = (lo + hi) / 2;
      if (mid >= 120 && mid <= 135) break;
      if ((mid < 120 && dc == 0) || (mid > 135 && dc == 127) || iter == 64) begin
        m_fail[c] = 1;
        break;
      end
      dc = (mid < 120) ? ((dc < 5) ? 0 : dc - 5) : dc + 1;
      m_dchg[c]++;
    end
    m_dc[c] = dc;
    g = GINIT; first = 1; up = 0;
    forever begin
      lo = clampi(off[c] - dc - amp(c, g));
      hi = clampi(off[c] - dc + amp(c, g));
      clip = (lo <= 10) || (hi >= 245);
      if (first) up = !clip;
      first = 0;
      if (up) begin
        if (clip) begin m_gain[c] = g - 1; break; end
        if (g == 15) begin m_gain[c] = 15; break; end
        g++; m_gchg[c]++;
      end else begin
        if (!clip) begin m_gain[c] = g; break; end
        if (g == 0) begin m_gain[c] = 0; m_fail[c] = 1; break; end
        g--; m_gchg[c]++;
      end
    end
  endtask

  function automatic int exp_sample();
    int n = hist.size();
`ifdef PPG_SAMPLE_AVG_EN
    return (hist[n-1] + hist[n-2] + hist[n-3] + hist[n-4]) >> 2;
`else
    return hist[n-1];
`endif
  endfunction

  task automatic tick();
    int c, a;
    @(negedge CLK);
    cyc++;
    if (busy && prev_busy && int'(led_en) == prev_led) begin
      c = (led_en == 2'b10) ? 1 : 0;
      if (int'(dc_comp) != prev_dc) o_dchg[c]++;
      if (int'(pga_gain) != prev_gain) o_gchg[c]++;
    end
    if (run_chk && sample_valid) begin
      check("smp_ch", sample_ch, run_ch);
      check("smp_dat", sample_data, exp_sample());
      check("slot_led", prev_led, 1 << run_ch);
      check("slot_dc", prev_dc, m_dc[run_ch]);
      check("slot_gain", prev_gain, m_gain[run_ch]);
      if (n_valid > 0) check("slot_period", cyc - last_v, SLOT);
      run_ch = (run_ch + 1) % NCH;
      check("slot0_led", led_en, 1 << run_ch);
      check("slot0_dc", dc_comp, m_dc[run_ch]);
      check("slot0_gain", pga_gain, m_gain[run_ch]);
      last_v = cyc;
      n_valid++;
    end
    prev_led = int'(led_en); prev_dc = int'(dc_comp); prev_gain = int'(pga_gain); prev_busy = busy;
    tog = !tog;
    c = (led_en == 2'b10) ? 1 : 0;
    a = amp(c, int'(pga_gain));
    if (done) adc = 8'($urandom_range(0, 255));
    else      adc = 8'(clampi(off[c] - int'(dc_comp) + (tog ? a : -a)));
    hist.push_back(int'(adc));
    if (hist.size() > 8) void'(hist.pop_front());
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("st_busy", busy, 1);
    check("st_done", done, 0);
    check("st_led", led_en, 1);
    check("st_dc", dc_comp, 127);
    check("st_gain", pga_gain, GINIT);
    check("st_fail", cal_fail, 0);
  endtask

  task automatic run_cal();
    int n;
    model(0); model(1);
    o_dchg[0] = 0; o_dchg[1] = 0; o_gchg[0] = 0; o_gchg[1] = 0;
    run_chk = 0;
    pulse_start();
    n = 0;
    while (!done && n < 8000) begin tick(); n++; end
    check("done_seen", done, 1);
    check("end_busy", busy, 0);
    check("cal_fail", cal_fail, m_fail[1] * 2 + m_fail[0]);
    for (int c = 0; c < NCH; c++) begin
      check("dc_steps", o_dchg[c], m_dchg[c]);
      check("gain_steps", o_gchg[c], m_gchg[c]);
    end
    check("run_led0", led_en, 1);
    check("run_dc0", dc_comp, m_dc[0]);
    check("run_gain0", pga_gain, m_gain[0]);
    n_valid = 0; run_ch = 0; run_chk = 1;
    repeat (4 * SLOT + 2) tick();
    run_chk = 0;
    check("n_slots", n_valid, 4);
  endtask

  initial begin
    bit cf;
    int n;
    for (int c = 0; c < 2; c++) begin off[c] = 200; amp0[c] = 20; kg[c] = 0; end
    repeat (3) tick();
    check("rst_led", led_en, 0);
    check("rst_dc", dc_comp, 127);
    check("rst_gain", pga_gain, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_smpv", sample_valid, 0);
    check("rst_clkf", clk_filter, 0);
    rst_n = 1'b1;
    tick();
    cf = clk_filter;
    tick();
    check("clkf_toggle", clk_filter, !cf);

    // ch0: mid = 200-dc, +/-20; ch1: gain clips from 10 upward.
    off[0] = 200; amp0[0] = 20; kg[0] = 0;
    off[1] = 200; amp0[1] = 0;  kg[1] = 12;
    run_cal();

    // ch0 pinned at 250: DC fails at the rail, gain walks down to 0 and fails.
    off[0] = 377; amp0[0] = 0; kg[0] = 0;
    off[1] = 200; amp0[1] = 20; kg[1] = 0;
    run_cal();

    // Reset for 3 cycles in the middle of RUN.
    rst_n = 1'b0;
    repeat (3) tick();
    check("mrst_led", led_en, 0);
    check("mrst_dc", dc_comp, 127);
    check("mrst_gain", pga_gain, 0);
    check("mrst_fail", cal_fail, 0);
    check("mrst_done", done, 0);
    check("mrst_busy", busy, 0);
    check("mrst_smp", sample_data, 0);
    check("mrst_smpch", sample_ch, 0);
    check("mrst_smpv", sample_valid, 0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle_done", done, 0);
    check("idle_led", led_en, 0);

    // Restart while channel 1 is in its gain search, after channel 0 has failed.
    model(0); model(1);
    pulse_start();
    n = 0;
    while (led_en != 2'b10 && n < 8000) begin tick(); n++; end
    check("reach_ch1", led_en, 2);
    n = 0;
    while (int'(pga_gain) == GINIT && n < 4000) begin tick(); n++; end
    check("ch1_gain_moved", int'(pga_gain) != GINIT, 1);
    check("pre_restart_fail", cal_fail[0], 1);
    run_cal();

    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        off[c]  = $urandom_range(150, 330);
        amp0[c] = $urandom_range(0, 40);
        kg[c]   = $urandom_range(0, 15);
      end
      run_cal();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ppg_cal_ctrl.md
Name: ppg_cal_ctrl

Overview:
Parametrised multi-channel LED/AFE calibration and sampling controller for the pulse-oximetry front end. On `start` it calibrates each of NUM_CH LED channels in turn:
- DC-compensation search until the signal midpoint is inside a target window.
- PGA gain search for the largest unclipped gain.

It then time-multiplexes the channels, applies each channel's stored settings, and emits one tagged ADC sample per slot. It sits between the ADC and the DC-comp DAC, PGA and LED drivers. A host or post-processing block consumes its sample stream.

Parameters:
- NUM_CH, 2, number of LED channels (1..8)
- ADC_W, 8, ADC sample width
- DC_W, 7, DC-compensation code width
- GAIN_W, 4, PGA gain code width
- WIN_LEN, 1000, ADC cycles per measurement window
- SETTLE, 4, cycles discarded after any dc_comp/pga_gain/led_en change
- TGT_LO, 120, lower midpoint target (inclusive)
- TGT_HI, 135, upper midpoint target (inclusive)
- CLIP_LO, 10, sample <= CLIP_LO counts as clipped
- CLIP_HI, 245, sample >= CLIP_HI counts as clipped
- DC_STEP_DN, 5, dc_comp decrement when midpoint < TGT_LO
- DC_STEP_UP, 1, dc_comp increment when midpoint > TGT_HI
- GAIN_INIT, 7, initial PGA gain per channel
- MAX_ITER, 64, maximum DC windows per channel before failure
- SLOT_LEN, 10, cycles per channel slot in RUN (must be >= SETTLE+4)

Ports:
- CLK, in, 1, system clock
- rst_n, in, 1, reset
- start, in, 1, synchronous pulse that (re)starts calibration
- adc, in, ADC_W, ADC sample; valid every cycle
- led_en, out, NUM_CH, one-hot LED enable
- dc_comp, out, DC_W, DC-compensation code
- pga_gain, out, GAIN_W, PGA gain code
- clk_filter, out, 1, CLK/2 filter clock
- busy, out, 1, calibration in progress
- done, out, 1, calibration finished; RUN active
- cal_fail, out, NUM_CH, per-channel calibration failure flag
- sample_data, out, ADC_W, RUN-mode sample
- sample_ch, out, max(1,$clog2(NUM_CH)), channel index of sample_data
- sample_valid, out, 1, one-cycle strobe for sample_data and sample_ch

Behaviour:
- Reset: reset rst_n, asynchronous, active-low; clock CLK. All logic is posedge CLK.
- Reset values:
  - led_en=0, dc_comp=all-ones (127), pga_gain=0.
  - clk_filter=0, busy=0, done=0, cal_fail=0.
  - sample_data=0, sample_ch=0, sample_valid=0.
  - State = IDLE.
- clk_filter toggles every cycle out of reset.
- States: IDLE, SETTLE_W, MEAS, DC_ADJ, GAIN_ADJ, NEXT_CH, RUN.
- start has priority in any state. On start:
  - ch=0, dc_comp=127, pga_gain=GAIN_INIT, led_en=1<<0.
  - cal_fail cleared, busy=1, done=0.
  - Go to SETTLE_W, phase=DC.
- SETTLE_W: wait SETTLE cycles, then MEAS.
- MEAS: track vmin/vmax over exactly WIN_LEN cycles (vmin seeded with all-ones, vmax with 0). Midpoint mid = (vmin+vmax)>>1, computed in ADC_W+1 bits. Go to DC_ADJ or GAIN_ADJ according to phase.
- DC_ADJ, by midpoint:
  - mid < TGT_LO: dc_comp -= DC_STEP_DN.
  - mid > TGT_HI: dc_comp += DC_STEP_UP.
  - Otherwise: store dc, set phase=GAIN, go to SETTLE_W.
  - Adjustments saturate at 0 and at max.
  - If an adjustment is needed while already at the limit, or the window count reaches MAX_ITER: set cal_fail[ch], store current dc, continue to the gain phase.
- GAIN_ADJ: clipped = (vmin <= CLIP_LO) || (vmax >= CLIP_HI).
  - The first gain window fixes the direction: unclipped → UP, clipped → DOWN.
  - UP: while unclipped and gain < max, increment gain and re-measure.
    - First clipped window: store gain-1.
    - Unclipped at max gain: store max.
  - DOWN: while clipped and gain > 0, decrement gain and re-measure.
    - First unclipped window: store gain.
    - Clipped at gain 0: store 0 and set cal_fail[ch].
  - Every gain change passes through SETTLE_W.
- NEXT_CH:
  - If ch < NUM_CH-1: ch+1, dc_comp=127, pga_gain=GAIN_INIT, led_en=1<<ch, phase=DC, go to SETTLE_W.
  - Else: busy=0, done=1, go to RUN with ch=0.
- RUN: each slot lasts SLOT_LEN cycles.
  - Slot cycle 0: drive led_en, dc_comp and pga_gain from the stored values of ch.
  - Last slot cycle: sample_valid=1, sample_data=adc, sample_ch=ch.
  - ch then wraps: NUM_CH-1 → 0.
- Reset mid-operation returns everything to reset values. Stored calibration values are not retained.

Optional Feature:
- Macro: PPG_SAMPLE_AVG_EN.
- Defined: sample_data is the mean of the last 4 adc samples of the slot. Sum is ADC_W+2 bits, result = sum>>2, truncated. The strobe stays on the last slot cycle.
- Undefined: sample_data is the single adc sample of the last slot cycle.

Test Plan:
All scenarios use WIN_LEN=16, NUM_CH=2.
- Reset: rst_n low for 3 cycles mid-RUN → all outputs at reset values; state IDLE; done=0.
- DC convergence: model mid=200-dc, amplitude ±20; pulse start → 10 DC_ADJ decrements; ch0 stores dc=77 (mid=123); cal_fail=0.
- Gain UP: clipping modelled for gain>=10 → stored gain 9; 4 gain windows counted.
- Gain DOWN/fail: adc constant 250 → gain steps 7→0; cal_fail[ch]=1; stored gain 0; next channel proceeds.
- RUN: SLOT_LEN=10 → sample_valid every 10 cycles; sample_ch 0,1,0,1; dc/gain switch to each channel's stored values at slot start; led_en 01/10.
- Restart: start asserted during ch1 GAIN → ch=0, dc=127, gain=7, cal_fail cleared, busy=1. With PPG_SAMPLE_AVG_EN, last 4 samples 100,101,102,104 → sample_data=101.
